axi_rd_serial_arbiter: RTL
==========================

Name: axi_rd_serial_arbiter

Overview:
- Shares one single-ID (ID zero) downstream AXI read channel between NumReq upstream read requesters.
- Round-robin arbitration on AR; an in-order FIFO of {requester index, upstream ID} routes R bursts back and restores the ID.
- Sits in front of a serialized memory or peripheral port, which returns R bursts strictly in AR order.

Parameters:
- NumReq, 4, number of upstream requesters (>=2)
- AddrWidth, 32, AR address width
- DataWidth, 64, R data width
- IdWidth, 4, upstream AR/R ID width (>=1)
- MaxTxns, 8, maximum in-flight read bursts; FIFO depth (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- slv_ar_valid_i  in  NumReq  per-requester AR valid
- slv_ar_ready_o  out  NumReq  per-requester AR ready
- slv_ar_addr_i  in  NumReq*AddrWidth  packed AR addresses; requester i at [i*AddrWidth +: AddrWidth]
- slv_ar_len_i  in  NumReq*8  packed AR burst lengths
- slv_ar_id_i  in  NumReq*IdWidth  packed AR IDs
- slv_r_valid_o  out  NumReq  per-requester R valid
- slv_r_ready_i  in  NumReq  per-requester R ready
- slv_r_data_o  out  DataWidth  R data, broadcast to all requesters
- slv_r_resp_o  out  2  R response, broadcast
- slv_r_last_o  out  1  R last, broadcast
- slv_r_id_o  out  IdWidth  restored upstream ID from FIFO head
- mst_ar_valid_o  out  1  downstream AR valid
- mst_ar_ready_i  in  1  downstream AR ready
- mst_ar_addr_o  out  AddrWidth  downstream AR address
- mst_ar_len_o  out  8  downstream AR length
- mst_ar_id_o  out  IdWidth  always '0
- mst_r_valid_i  in  1  downstream R valid
- mst_r_ready_o  out  1  downstream R ready
- mst_r_data_i  in  DataWidth  downstream R data
- mst_r_resp_i  in  2  downstream R response
- mst_r_last_i  in  1  downstream R last
- inflight_o  out  $clog2(MaxTxns+1)  outstanding bursts (FIFO occupancy)

Behaviour:
- Reset (rst_i high, async): FSM=Idle, rr pointer=0, FIFO empty, inflight_o=0. All valid/ready outputs 0; mst_ar_id_o=0; data outputs don't-care.
- FSM Idle:
  - If FIFO not full and any slv_ar_valid_i bit set, latch the grant index g: first set bit at or after the rr pointer, wrapping modulo NumReq.
  - Same cycle: drive mst_ar_valid_o=1 with requester g's addr/len. slv_ar_ready_o[g] = mst_ar_ready_i; all other ready bits 0.
  - If handshake this cycle: push {g, id[g]}, rr pointer = (g+1) mod NumReq, stay Idle. Otherwise go to Hold.
- FSM Hold:
  - Keep the latched g; do not re-arbitrate, even if a higher-priority request appears.
  - mst_ar_valid_o=1 with requester g's fields; slv_ar_ready_o[g] = mst_ar_ready_i.
  - On handshake: push, advance rr pointer, return to Idle.
  - Requester g must hold valid stable per AXI; deassertion by g is a protocol violation (assertion, not handled).
- Full gating: FIFO full (registered occupancy == MaxTxns) blocks a new grant in Idle. A Hold already in progress is never entered while full, since grant requires not-full.
- Push vs pop on the same cycle is legal; occupancy is unchanged.
- FIFO is non-fall-through: a pushed entry is visible the cycle after push.
- R path:
  - FIFO empty: mst_r_ready_o=0 and slv_r_valid_o=0. A downstream R beat arriving in the same cycle as its AR handshake stalls one cycle.
  - FIFO non-empty with head {h, id}: slv_r_valid_o[h] = mst_r_valid_i, other bits 0; mst_r_ready_o = slv_r_ready_i[h]; slv_r_id_o = id. Data, resp and last pass through combinationally.
  - Pop on (mst_r_valid_i & mst_r_ready_o & mst_r_last_i).
- Latency: AR path zero-cycle combinational pass-through on grant; R path combinational.
- inflight_o = FIFO occupancy: +1 on push, -1 on pop, saturating at 0..MaxTxns by construction.
- Reset mid-burst clears all state immediately; partial bursts are dropped, and the environment must also reset.

Test Plan:
- NumReq=4: requester 2 issues AR id=5 len=3 with mst_ar_ready_i=1 -> mst_ar_valid_o same cycle, mst_ar_id_o=0; 4 R beats -> slv_r_valid_o=4'b0100, slv_r_id_o=5; inflight_o goes 1 then 0 after last.
- Requesters 0,1,3 valid simultaneously, ready always 1 -> grants in order 0,1,3,0; rr pointer wraps correctly.
- Requester 1 granted with mst_ar_ready_i=0 for 3 cycles while requester 0 raises valid -> addr stays requester 1's until handshake; requester 0 granted next.
- MaxTxns=2: three back-to-back ARs, no R -> third AR stalls (mst_ar_valid_o=0, inflight_o=2); after one R last, third AR issues the following cycle.
- Downstream R valid in the same cycle as the first AR handshake -> mst_r_ready_o=0 that cycle, accepted the next cycle.
- rst_i asserted mid-burst with inflight_o=2 -> all valids 0 and inflight_o=0 immediately (async); normal operation resumes after release.

Source files
------------

// File: rtl/axi_rd_serial_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_serial_arbiter
//
// Shares one downstream AXI read channel (single ID, always zero) between
// NumReq upstream read requesters. AR requests are granted round-robin and
// forwarded combinationally. Each accepted AR pushes {requester index,
// upstream ID} into an in-order FIFO. The downstream port returns R bursts
// strictly in AR order, so the FIFO head tells us which requester owns the
// current R burst and which ID to restore.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   slv_ar_valid_i/ready_o  per-requester AR handshake
//   slv_ar_addr_i/len_i/id_i  packed per-requester AR fields (requester i at
//                           [i*W +: W])
//   slv_r_valid_o/ready_i   per-requester R handshake
//   slv_r_data_o/resp_o/last_o  R payload broadcast to all requesters
//   slv_r_id_o             upstream ID restored from the FIFO head
//   mst_ar_*               downstream AR channel (ID tied to zero)
//   mst_r_*                downstream R channel
//   inflight_o             number of outstanding bursts (FIFO occupancy)
// ---------------------------------------------------------------------------
module axi_rd_serial_arbiter #(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 4,
  parameter int MaxTxns   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             slv_ar_valid_i,
  output logic [NumReq-1:0]             slv_ar_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   slv_ar_addr_i,
  input  logic [NumReq*8-1:0]           slv_ar_len_i,
  input  logic [NumReq*IdWidth-1:0]     slv_ar_id_i,
  output logic [NumReq-1:0]             slv_r_valid_o,
  input  logic [NumReq-1:0]             slv_r_ready_i,
  output logic [DataWidth-1:0]          slv_r_data_o,
  output logic [1:0]                    slv_r_resp_o,
  output logic                          slv_r_last_o,
  output logic [IdWidth-1:0]            slv_r_id_o,
  output logic                          mst_ar_valid_o,
  input  logic                          mst_ar_ready_i,
  output logic [AddrWidth-1:0]          mst_ar_addr_o,
  output logic [7:0]                    mst_ar_len_o,
  output logic [IdWidth-1:0]            mst_ar_id_o,
  input  logic                          mst_r_valid_i,
  output logic                          mst_r_ready_o,
  input  logic [DataWidth-1:0]          mst_r_data_i,
  input  logic [1:0]                    mst_r_resp_i,
  input  logic                          mst_r_last_i,
  output logic [$clog2(MaxTxns+1)-1:0]  inflight_o
);

  localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW  = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int CntW  = $clog2(MaxTxns + 1);
  localparam int Depth = 1 << PtrW;

  typedef enum logic {
    Idle,
    Hold
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     rrPtr_q, rrPtr_d;
  logic [PtrW-1:0]     wrPtr_q, rdPtr_q;
  logic [CntW-1:0]     count_q;
  logic [IdxW-1:0]     idxMem_q [Depth];
  logic [IdWidth-1:0]  idMem_q  [Depth];

  logic                anyValid;
  logic [IdxW-1:0]     arbGrant;
  logic [IdxW-1:0]     curGrant;
  logic                arValid;
  logic                arPush;
  logic                rPop;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [IdxW-1:0]     headIdx;
  logic [IdWidth-1:0]  headId;
  logic [AddrWidth-1:0] curAddr;
  logic [7:0]          curLen;
  logic [IdWidth-1:0]  curId;
  logic                rReady;
  logic                holdReqValid;

  assign fifoFull  = (count_q == CntW'(MaxTxns));
  assign fifoEmpty = (count_q == '0);
  assign headIdx   = idxMem_q[rdPtr_q];
  assign headId    = idMem_q[rdPtr_q];

  // Round-robin search: first valid requester at or after the pointer,
  // wrapping modulo NumReq.
  always_comb begin
    logic [IdxW-1:0] cand;
    anyValid = 1'b0;
    arbGrant = '0;
    cand     = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdxW'((int'(rrPtr_q) + k) % NumReq);
      if (!anyValid && slv_ar_valid_i[cand]) begin
        anyValid = 1'b1;
        arbGrant = cand;
      end
    end
  end

  // Once a grant is stalled by the downstream, the latched index wins over
  // any fresh arbitration so the AR payload stays stable until accepted.
  // Reset forces the AR valid low even though it is otherwise combinational.
  always_comb begin
    curGrant = (state_q == Hold) ? grant_q : arbGrant;
    arValid  = 1'b0;
    if (!rst_i) begin
      if (state_q == Hold) begin
        arValid = 1'b1;
      end else begin
        arValid = anyValid && !fifoFull;
      end
    end
    arPush = arValid && mst_ar_ready_i;
  end

  // Select the granted requester's AR fields and steer per-requester
  // handshakes for both AR and R.
  always_comb begin
    curAddr        = '0;
    curLen         = '0;
    curId          = '0;
    slv_ar_ready_o = '0;
    slv_r_valid_o  = '0;
    rReady         = 1'b0;
    holdReqValid   = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (curGrant == IdxW'(i)) begin
        curAddr           = slv_ar_addr_i[i*AddrWidth +: AddrWidth];
        curLen            = slv_ar_len_i[i*8 +: 8];
        curId             = slv_ar_id_i[i*IdWidth +: IdWidth];
        slv_ar_ready_o[i] = arValid && mst_ar_ready_i;
      end
      if (!fifoEmpty && (headIdx == IdxW'(i))) begin
        slv_r_valid_o[i] = mst_r_valid_i;
        rReady           = slv_r_ready_i[i];
      end
      if (grant_q == IdxW'(i)) begin
        holdReqValid = slv_ar_valid_i[i];
      end
    end
  end

  assign mst_ar_valid_o = arValid;
  assign mst_ar_addr_o  = curAddr;
  assign mst_ar_len_o   = curLen;
  assign mst_ar_id_o    = '0;

  assign mst_r_ready_o  = rReady;
  assign slv_r_data_o   = mst_r_data_i;
  assign slv_r_resp_o   = mst_r_resp_i;
  assign slv_r_last_o   = mst_r_last_i;
  assign slv_r_id_o     = headId;

  // A burst retires only on its last beat; the FIFO head then moves on to
  // the next outstanding burst.
  assign rPop       = mst_r_valid_i && rReady && mst_r_last_i;
  assign inflight_o = count_q;

  // Grant FSM next-state: Idle grants and forwards immediately, Hold keeps
  // a stalled grant until the downstream accepts it.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rrPtr_d = rrPtr_q;
    case (state_q)
      Idle: begin
        if (arValid) begin
          grant_d = arbGrant;
          if (!mst_ar_ready_i) begin
            state_d = Hold;
          end
        end
      end
      Hold: begin
        if (mst_ar_ready_i) begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
    if (arPush) begin
      rrPtr_d = (curGrant == IdxW'(NumReq - 1)) ? '0 : curGrant + IdxW'(1);
    end
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
      grant_q <= '0;
      rrPtr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap at MaxTxns so non-power-of-two
  // depths work. Simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (arPush) begin
        wrPtr_q <= (wrPtr_q == PtrW'(MaxTxns - 1)) ? '0 : wrPtr_q + PtrW'(1);
      end
      if (rPop) begin
        rdPtr_q <= (rdPtr_q == PtrW'(MaxTxns - 1)) ? '0 : rdPtr_q + PtrW'(1);
      end
      case ({arPush, rPop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset; entries are only read while occupancy is
  // non-zero.
  always_ff @(posedge clk_i) begin
    if (arPush) begin
      idxMem_q[wrPtr_q] <= curGrant;
      idMem_q[wrPtr_q]  <= curId;
    end
  end

`ifndef SYNTHESIS
  // A stalled requester must keep its AR valid asserted until accepted.
  holdValidStable: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == Hold) |-> holdReqValid);
`endif

endmodule
